// File: rtl/pll_seq_pkg.sv
// Shared types and helpers for the PLL reset sequencer: FSM state encoding,
// a constant max helper and a saturating increment for the debug counters.
package pll_seq_pkg;

  typedef enum logic [1:0] {
    PLL_RST   = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } pll_seq_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Increments v but sticks at 2^w-1 instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] top;
    top = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (v >= top) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchronizer that brings the asynchronous PLL lock flag into the
// reference-clock domain; both stages clear on synchronous reset.
module pll_lock_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic sync_o
);

  (* ASYNC_REG = "TRUE" *) logic meta_q;
  (* ASYNC_REG = "TRUE" *) logic sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL bring-up sequencer: pulses the PLL reset, waits for a stable lock, then
// releases the core reset. Define PLL_SEQ_RETRY_EN to enable the lock timeout
// that re-pulses the PLL reset and counts retries.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int STABLE_CYCLES = 1024,
  parameter int CNT_W         = 8
) (
  input  logic             clkin_i,
  input  logic             rst_i,
  input  logic             locked_i,
  output logic             pll_rst_o,
  output logic             sys_rst_o,
  output logic             ready_o,
  output logic [CNT_W-1:0] loss_cnt_o,
  output logic [CNT_W-1:0] retry_cnt_o,
  output pll_seq_state_t   state_o
);

`ifdef PLL_SEQ_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif

  // The timeout only widens the shared counter when the retry path exists.
  localparam int CNT_MAX = max_int(max_int(RST_CYCLES, STABLE_CYCLES),
                                   RETRY_EN ? LOCK_TIMEOUT : 1);
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] RST_LD = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] STB_LD = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] ONE    = CW'(1);
`ifdef PLL_SEQ_RETRY_EN
  localparam logic [CW-1:0] TO_LD  = CW'(LOCK_TIMEOUT - 1);
`else
  localparam logic [CW-1:0] TO_LD  = '0;
`endif

  logic           lk_s;
  pll_seq_state_t state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0] loss_q, loss_d;
`ifdef PLL_SEQ_RETRY_EN
  logic [CNT_W-1:0] retry_q, retry_d;
`endif

  pll_lock_sync u_lock_sync (
    .clk_i   (clkin_i),
    .rst_i   (rst_i),
    .async_i (locked_i),
    .sync_o  (lk_s)
  );

  always_ff @(posedge clkin_i) begin
    if (rst_i) begin
      state_q <= PLL_RST;
      cnt_q   <= RST_LD;
      loss_q  <= '0;
`ifdef PLL_SEQ_RETRY_EN
      retry_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      loss_q  <= loss_d;
`ifdef PLL_SEQ_RETRY_EN
      retry_q <= retry_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    loss_d  = loss_q;
`ifdef PLL_SEQ_RETRY_EN
    retry_d = retry_q;
`endif
    unique case (state_q)
      PLL_RST: begin
        if (cnt_q == '0) begin
          state_d = WAIT_LOCK;
          cnt_d   = TO_LD;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      WAIT_LOCK: begin
        // Lock detect is checked first so it wins over a coincident timeout.
        if (lk_s) begin
          state_d = STABLE;
          cnt_d   = STB_LD;
        end
`ifdef PLL_SEQ_RETRY_EN
        else if (cnt_q == '0) begin
          state_d = PLL_RST;
          cnt_d   = RST_LD;
          retry_d = CNT_W'(sat_inc(32'(retry_q), CNT_W));
        end else begin
          cnt_d = cnt_q - ONE;
        end
`endif
      end
      STABLE: begin
        if (!lk_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = TO_LD;
        end else if (cnt_q == '0) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      RUN: begin
        if (!lk_s) begin
          state_d = PLL_RST;
          cnt_d   = RST_LD;
          loss_d  = CNT_W'(sat_inc(32'(loss_q), CNT_W));
        end
      end
      default: begin
        state_d = PLL_RST;
        cnt_d   = RST_LD;
      end
    endcase
  end

  // Outputs decode the state register only, so locked_i never reaches them combinationally.
  assign pll_rst_o  = (state_q == PLL_RST);
  assign sys_rst_o  = (state_q != RUN);
  assign ready_o    = (state_q == RUN);
  assign loss_cnt_o = loss_q;
  assign state_o    = state_q;
`ifdef PLL_SEQ_RETRY_EN
  assign retry_cnt_o = retry_q;
`else
  assign retry_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with small timing parameters; the
// timeout scenario is chosen by whether PLL_SEQ_RETRY_EN is defined.
module tb_pll_reset_sequencer;
  import pll_seq_pkg::*;

  localparam int RC  = 4;
  localparam int LT  = 32;
  localparam int SC  = 8;
  localparam int CW  = 3;
  localparam int REL = 2 + 1 + SC;
  localparam int PER = RC + LT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic locked = 1'b0;
  logic pll_rst, sys_rst, ready;
  logic [CW-1:0] loss_cnt, retry_cnt;
  pll_seq_state_t state;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pll_reset_sequencer #(
    .RST_CYCLES    (RC),
    .LOCK_TIMEOUT  (LT),
    .STABLE_CYCLES (SC),
    .CNT_W         (CW)
  ) dut (
    .clkin_i     (clk),
    .rst_i       (rst),
    .locked_i    (locked),
    .pll_rst_o   (pll_rst),
    .sys_rst_o   (sys_rst),
    .ready_o     (ready),
    .loss_cnt_o  (loss_cnt),
    .retry_cnt_o (retry_cnt),
    .state_o     (state)
  );

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; locked = 1'b0;
    step(3);
    vectors++; if (state !== PLL_RST) begin miscompares++; $display("FAIL reset_state: got %0d expected %0d", state, PLL_RST); end
    vectors++; if (pll_rst !== 1'b1) begin miscompares++; $display("FAIL reset_pll_rst: got %b expected 1", pll_rst); end
    vectors++; if (sys_rst !== 1'b1) begin miscompares++; $display("FAIL reset_sys_rst: got %b expected 1", sys_rst); end
    vectors++; if (ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready: got %b expected 0", ready); end
    vectors++; if (loss_cnt !== 3'd0) begin miscompares++; $display("FAIL reset_loss: got %0d expected 0", loss_cnt); end
    vectors++; if (retry_cnt !== 3'd0) begin miscompares++; $display("FAIL reset_retry: got %0d expected 0", retry_cnt); end
  endtask

  task automatic test_clean_bringup();
    logic exp;
    rst = 1'b0;
    for (int i = 1; i <= RC; i++) begin
      step(1);
      exp = (i < RC);
      vectors++; if (pll_rst !== exp) begin miscompares++; $display("FAIL bringup_pll_rst edge %0d: got %b expected %b", i, pll_rst, exp); end
    end
    step(10 - RC);
    locked = 1'b1;
    for (int i = 1; i <= REL; i++) begin
      step(1);
      exp = (i < REL);
      vectors++; if (sys_rst !== exp) begin miscompares++; $display("FAIL bringup_sys_rst edge %0d: got %b expected %b", i, sys_rst, exp); end
    end
    vectors++; if (ready !== 1'b1) begin miscompares++; $display("FAIL bringup_ready: got %b expected 1", ready); end
    vectors++; if (loss_cnt !== 3'd0) begin miscompares++; $display("FAIL bringup_loss: got %0d expected 0", loss_cnt); end
    vectors++; if (retry_cnt !== 3'd0) begin miscompares++; $display("FAIL bringup_retry: got %0d expected 0", retry_cnt); end
  endtask

  task automatic test_lock_loss();
    logic exp;
    locked = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step(1);
      exp = (i == 3);
      vectors++; if (sys_rst !== exp) begin miscompares++; $display("FAIL loss_sys_rst edge %0d: got %b expected %b", i, sys_rst, exp); end
      vectors++; if (pll_rst !== exp) begin miscompares++; $display("FAIL loss_pll_rst edge %0d: got %b expected %b", i, pll_rst, exp); end
      vectors++; if (ready !== !exp) begin miscompares++; $display("FAIL loss_ready edge %0d: got %b expected %b", i, ready, !exp); end
    end
    vectors++; if (loss_cnt !== 3'd1) begin miscompares++; $display("FAIL loss_cnt: got %0d expected 1", loss_cnt); end
    step(RC);
    vectors++; if (state !== WAIT_LOCK) begin miscompares++; $display("FAIL loss_relock_state: got %0d expected %0d", state, WAIT_LOCK); end
    vectors++; if (pll_rst !== 1'b0) begin miscompares++; $display("FAIL loss_relock_pll_rst: got %b expected 0", pll_rst); end
  endtask

  task automatic test_glitchy_lock();
    logic exp;
    step(2);
    locked = 1'b1;
    step(5);
    vectors++; if (state !== STABLE) begin miscompares++; $display("FAIL glitch_stable: got %0d expected %0d", state, STABLE); end
    locked = 1'b0;
    step(3);
    vectors++; if (state !== WAIT_LOCK) begin miscompares++; $display("FAIL glitch_abort: got %0d expected %0d", state, WAIT_LOCK); end
    vectors++; if (loss_cnt !== 3'd1) begin miscompares++; $display("FAIL glitch_abort_loss: got %0d expected 1", loss_cnt); end
    locked = 1'b1;
    for (int i = 1; i <= REL; i++) begin
      step(1);
      exp = (i < REL);
      vectors++; if (sys_rst !== exp) begin miscompares++; $display("FAIL glitch_sys_rst edge %0d: got %b expected %b", i, sys_rst, exp); end
    end
    vectors++; if (ready !== 1'b1) begin miscompares++; $display("FAIL glitch_ready: got %b expected 1", ready); end
    vectors++; if (loss_cnt !== 3'd1) begin miscompares++; $display("FAIL glitch_loss: got %0d expected 1", loss_cnt); end
    vectors++; if (retry_cnt !== 3'd0) begin miscompares++; $display("FAIL glitch_retry: got %0d expected 0", retry_cnt); end
  endtask

  task automatic test_mid_reset();
    locked = 1'b0;
    step(3);
    vectors++; if (loss_cnt !== 3'd2) begin miscompares++; $display("FAIL midrst_loss_before: got %0d expected 2", loss_cnt); end
    step(RC);
    locked = 1'b1;
    step(3);
    vectors++; if (state !== STABLE) begin miscompares++; $display("FAIL midrst_in_stable: got %0d expected %0d", state, STABLE); end
    rst = 1'b1;
    step(1);
    vectors++; if (state !== PLL_RST) begin miscompares++; $display("FAIL midrst_state: got %0d expected %0d", state, PLL_RST); end
    vectors++; if (pll_rst !== 1'b1) begin miscompares++; $display("FAIL midrst_pll_rst: got %b expected 1", pll_rst); end
    vectors++; if (sys_rst !== 1'b1) begin miscompares++; $display("FAIL midrst_sys_rst: got %b expected 1", sys_rst); end
    vectors++; if (ready !== 1'b0) begin miscompares++; $display("FAIL midrst_ready: got %b expected 0", ready); end
    vectors++; if (loss_cnt !== 3'd0) begin miscompares++; $display("FAIL midrst_loss: got %0d expected 0", loss_cnt); end
    vectors++; if (retry_cnt !== 3'd0) begin miscompares++; $display("FAIL midrst_retry: got %0d expected 0", retry_cnt); end
    rst = 1'b0;
    locked = 1'b0;
  endtask

`ifdef PLL_SEQ_RETRY_EN
  task automatic test_timeout_retry();
    logic exp_p;
    logic [CW-1:0] exp_r;
    for (int e = 1; e <= 300; e++) begin
      step(1);
      exp_p = ((e % PER) < RC);
      exp_r = CW'(((e / PER) > 7) ? 7 : (e / PER));
      vectors++; if (pll_rst !== exp_p) begin miscompares++; $display("FAIL retry_pll_rst edge %0d: got %b expected %b", e, pll_rst, exp_p); end
      vectors++; if (retry_cnt !== exp_r) begin miscompares++; $display("FAIL retry_cnt edge %0d: got %0d expected %0d", e, retry_cnt, exp_r); end
    end
  endtask
`else
  task automatic test_no_retry();
    logic exp_p;
    for (int e = 1; e <= 1000; e++) begin
      step(1);
      exp_p = (e < RC);
      vectors++; if (pll_rst !== exp_p) begin miscompares++; $display("FAIL noretry_pll_rst edge %0d: got %b expected %b", e, pll_rst, exp_p); end
      vectors++; if (retry_cnt !== 3'd0) begin miscompares++; $display("FAIL noretry_cnt edge %0d: got %0d expected 0", e, retry_cnt); end
    end
  endtask
`endif

  task automatic test_relock_after_hold();
    logic exp;
    logic [CW-1:0] exp_r;
`ifdef PLL_SEQ_RETRY_EN
    exp_r = 3'd7;
`else
    exp_r = 3'd0;
`endif
    locked = 1'b1;
    for (int i = 1; i <= REL; i++) begin
      step(1);
      exp = (i < REL);
      vectors++; if (sys_rst !== exp) begin miscompares++; $display("FAIL relock_sys_rst edge %0d: got %b expected %b", i, sys_rst, exp); end
    end
    vectors++; if (ready !== 1'b1) begin miscompares++; $display("FAIL relock_ready: got %b expected 1", ready); end
    vectors++; if (retry_cnt !== exp_r) begin miscompares++; $display("FAIL relock_retry: got %0d expected %0d", retry_cnt, exp_r); end
    vectors++; if (loss_cnt !== 3'd0) begin miscompares++; $display("FAIL relock_loss: got %0d expected 0", loss_cnt); end
  endtask

  initial begin
    test_reset();
    test_clean_bringup();
    test_lock_loss();
    test_glitchy_lock();
    test_mid_reset();
`ifdef PLL_SEQ_RETRY_EN
    test_timeout_retry();
`else
    test_no_retry();
`endif
    test_relock_after_hold();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pll_reset_sequencer.md
# pll_reset_sequencer

Sequences PLL bring-up for the system. It drives the PLL `RST` input, watches the PLL `locked` output, and releases the core reset only after lock has been stable for a programmed time. It counts lock losses and relock attempts for debug. It runs on the 25 MHz reference clock `clkin`, which is valid whether or not the PLL is locked, and sits between the board clock pin, the `pll` instance and the core reset tree.

## Interface
- `RST_CYCLES`, 16: cycles `pll_rst` is held high per PLL reset pulse (≥1).
- `LOCK_TIMEOUT`, 65536: cycles allowed in WAIT_LOCK before a relock attempt (≥1).
- `STABLE_CYCLES`, 1024: consecutive synchronized-locked cycles required before release (≥1).
- `CNT_W`, 8: width of the saturating debug counters.
- `clkin`  in  1  reference clock, 25 MHz; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `locked`  in  1  PLL lock output, asynchronous to `clkin`.
- `pll_rst`  out  1  drives PLL `RST`; high = PLL held in reset.
- `sys_rst`  out  1  active-high core reset, `clkin` domain; the consumer re-synchronizes it.
- `ready`  out  1  high while in RUN.
- `loss_cnt`  out  CNT_W  number of lock losses seen in RUN; saturates.
- `retry_cnt`  out  CNT_W  number of timeout relock attempts; saturates.

## Operation
- `locked` passes through a 2-flop synchronizer; `lk_s` below is the synchronized value.
- One down-counter `cnt` is shared by all states; its width is `$clog2` of max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)+1.
- States and transitions:
  - **PLL_RST**: `pll_rst`=1, `sys_rst`=1. Loaded with RST_CYCLES-1 on entry. Goes to WAIT_LOCK when `cnt`==0.
  - **WAIT_LOCK**: `pll_rst`=0, `sys_rst`=1. Loaded with LOCK_TIMEOUT-1.
    - `lk_s`=1 → STABLE.
    - `cnt`==0 with `lk_s`=0 → PLL_RST and `retry_cnt`++ (see Configuration).
  - **STABLE**: `pll_rst`=0, `sys_rst`=1. Loaded with STABLE_CYCLES-1.
    - `lk_s`=0 → WAIT_LOCK, timeout reloaded, no count.
    - `cnt`==0 with `lk_s`=1 → RUN.
  - **RUN**: `sys_rst`=0, `ready`=1. `lk_s`=0 → PLL_RST and `loss_cnt`++.
- Both counters saturate at 2^CNT_W-1 and never wrap. Only `rst` clears them.
- Precedence when events coincide in the same cycle:
  - `rst` beats everything.
  - In STABLE, a drop of `lk_s` beats expiry of `cnt`.
  - In WAIT_LOCK, lock detect beats timeout.
- `rst` asserted mid-operation, in any state, forces the reset values on the next edge. The debug counters clear.

## Timing
- Reset values: state PLL_RST, `pll_rst`=1, `sys_rst`=1, `ready`=0, `loss_cnt`=0, `retry_cnt`=0, synchronizer flops 0.
- All outputs are registered and decoded from the state register. There is no combinational path from `locked`.
- The first `rst`=0 edge starts PLL_RST. `pll_rst` stays high for exactly RST_CYCLES cycles after `rst` falls.
- Synchronizer latency is 2 cycles. Timing from a `locked` rise to `sys_rst` fall:
  - Minimum latency is 2 + 1 + STABLE_CYCLES cycles when `locked` is already high on entry to WAIT_LOCK.
  - WAIT_LOCK to STABLE takes 1 cycle after `lk_s` rises.
- Timing from a `locked` fall in RUN:
  - `sys_rst` rises and `ready` falls 3 cycles later: 2 sync + 1 state.
  - `pll_rst` rises in that same cycle.
- `loss_cnt` and `retry_cnt` update on the same edge as the state transition that causes them.

## Configuration
- `PLL_SEQ_RETRY_EN` defined: WAIT_LOCK timeout behaves as described in Operation (re-pulse `pll_rst`, `retry_cnt`++).
- `PLL_SEQ_RETRY_EN` undefined:
  - WAIT_LOCK has no timeout and waits indefinitely for lock.
  - `retry_cnt` is tied to 0.
  - A loss in RUN still re-enters PLL_RST.
  - The timeout compare logic is not generated, and `LOCK_TIMEOUT` is excluded from the counter width.

## Structure
- Package `pll_seq_pkg` holds:
  - the state enum `pll_seq_state_t` (PLL_RST, WAIT_LOCK, STABLE, RUN), 2-bit encoding;
  - a `sat_inc` function for the saturating counters.
- Sub-module `pll_lock_sync`: 2-flop synchronizer with reset to 0 and `(* ASYNC_REG *)`-style attributes. It is instantiated once for `locked`.

## Test plan
Bench parameters: RST_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8, CNT_W=3, macro defined unless noted.
- **Clean bring-up**: release `rst`, raise `locked` 10 cycles later.
  - `pll_rst` is high 4 cycles.
  - `sys_rst` falls exactly 2+1+8 cycles after `locked` rises.
  - `ready`=1 and both counters stay 0.
- **Glitchy lock**: pulse `locked` high 5 cycles, low 3, then high steady.
  - STABLE aborts to WAIT_LOCK with no count.
  - Release occurs 11 cycles after the final rise.
- **Timeout retry**: hold `locked` low.
  - `pll_rst` re-pulses every 4+32 cycles.
  - `retry_cnt` counts to 7 and holds at 7 after the 8th timeout.
- **Lock loss in RUN**: drop `locked` while `ready`=1.
  - 3 cycles later `sys_rst`=1, `pll_rst`=1, `loss_cnt`=1.
  - Relock releases again.
- **Mid-operation reset**: assert `rst` for 1 cycle in STABLE with `loss_cnt`=2.
  - Next edge: state PLL_RST, `pll_rst`=1, `sys_rst`=1, counters 0.
- **Macro undefined**: hold `locked` low for 1000 cycles.
  - `pll_rst` stays 0 after the initial 4-cycle pulse.
  - `retry_cnt`=0.
  - Raising `locked` releases after 11 cycles.
